// File: rtl/dbus_resp_pkg.sv
// Shared types and helpers for the dbus_sram_resp data-bus responder.
package dbus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth_words);
    return (addr >= base) && (addr < base + (depth_words << 2));
  endfunction

endpackage

// File: rtl/sram_1rw_bm.sv
// Single-port synchronous SRAM with per-byte write enables and a registered,
// clearable read port.
module sram_1rw_bm
  import dbus_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           we,
  input  logic                           clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [LANES-1:0]               bmask,
  output logic [DATA_WIDTH-1:0]          q
);

  localparam int LANE_W = DATA_WIDTH / LANES;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int l = 0; l < LANES; l++) begin
        if (bmask[l]) mem[addr][LANE_W*l +: LANE_W] <= wdata[LANE_W*l +: LANE_W];
      end
    end
  end

  // Read register only moves on a read or a clear, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (rst)            q <= '0;
    else if (clr)       q <= '0;
    else if (en && !we) q <= mem[addr];
  end

endmodule

// File: rtl/dbus_sram_resp.sv
// EXU data-bus responder backed by a word SRAM with programmable wait states.
// Optional completed-access counters under DBUS_SRAM_RESP_STATS_EN.
module dbus_sram_resp
  import dbus_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000_0000,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [LANES-1:0]      wmask_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  hold_flag_o,
  output logic                  err_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, hit_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]  wmask_q;
  logic              accept, commit;

  always_comb begin
    state_nx    = state;
    hold_flag_o = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        hold_flag_o = req_i;
        if (req_i) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        hold_flag_o = 1'b1;
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      hit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= commit && !hit_q;
      if (accept) begin
        cnt   <= CNT_W'(WAIT_CYCLES);
        we_q  <= we_i;
        hit_q <= addr_hit(64'(addr_i), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Request payload is only consumed under hit_q/we_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr_i[IDX_W+1:2];
      wdata_q <= wdata_i;
      wmask_q <= wmask_i;
    end
  end

  sram_1rw_bm #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .en   (commit && hit_q && !rst),
    .we   (we_q),
    .clr  (commit && !hit_q),
    .addr (idx_q),
    .wdata(wdata_q),
    .bmask(wmask_q),
    .q    (rdata_o)
  );

  assign err_o = err_q;

`ifdef DBUS_SRAM_RESP_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (commit && hit_q) begin
      if (we_q) wr_cnt <= wr_cnt + 32'd1;
      else      rd_cnt <= rd_cnt + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt;
  assign wr_cnt_o = wr_cnt;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule
